coarse_timestamp_capture: RTL

//  Downstream consumer of the event synchronizer output. Rising-edge detects

---
 rtl/tdc_pkg.sv | 15 +
 rtl/tdc_ts_fifo.sv | 61 ++++++
 rtl/coarse_timestamp_capture.sv | 112 +++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// Shared types for the coarse timestamp capture path.
// Counter width default and the capture FSM state encoding.
package tdc_pkg;

  localparam int TDC_COUNTER_WIDTH = 32;

  typedef logic [TDC_COUNTER_WIDTH-1:0] timestamp_t;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    DEAD     = 2'd2
  } capture_state_t;

endpackage

// File: rtl/tdc_ts_fifo.sv
// Synchronous show-ahead timestamp FIFO.
// When empty the output holds the last popped word.
module tdc_ts_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_last;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  // A full FIFO still takes a push when the head leaves the same cycle
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_count = r_count;
  assign o_data  = o_empty ? r_last : r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) begin
        r_rd   <= r_rd + AW'(1);
        r_last <= r_mem[r_rd];
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/coarse_timestamp_capture.sv
// Edge-detects event_sync and stamps accepted rises with a coarse
// counter; stamps are queued in a show-ahead FIFO for the readout.
module coarse_timestamp_capture
  import tdc_pkg::*;
#(
  parameter int COUNTER_WIDTH = TDC_COUNTER_WIDTH,
  parameter int FIFO_DEPTH    = 8,
  parameter int DEAD_TIME     = 4
) (
  input  logic                          clk_input,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          event_sync,
  output logic [COUNTER_WIDTH-1:0]      ts_data,
  output logic                          ts_valid,
  input  logic                          ts_ready,
  output logic [$clog2(FIFO_DEPTH):0]   ts_count,
  output logic                          overflow_sticky,
  input  logic                          clear_overflow,
  output logic                          rollover_pulse
);

  localparam int DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;

  capture_state_t           r_state;
  capture_state_t           w_next;
  logic [COUNTER_WIDTH-1:0] r_cnt;
  logic [DW-1:0]            r_dead;
  logic                     r_prev;
  logic                     r_roll;
  logic                     r_ovf;
  logic                     w_rise;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_drop;

  assign w_rise = event_sync & ~r_prev;
  assign w_pop  = ts_valid & ts_ready;
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge clk_input) begin
    if (!reset) r_state <= DISABLED;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      DISABLED: if (enable) w_next = ARMED;
      ARMED: begin
        if (!enable)     w_next = DISABLED;
        else if (w_rise) w_next = DEAD;
      end
      DEAD: begin
        if (!enable)            w_next = DISABLED;
        else if (r_dead == '0)  w_next = ARMED;
      end
      default: w_next = DISABLED;
    endcase
  end

  always_comb begin
    w_push = 1'b0;
    unique case (r_state)
      ARMED:   w_push = enable & w_rise;
      default: w_push = 1'b0;
    endcase
  end

  // prev resets high so a level held across reset is not a rise
  always_ff @(posedge clk_input) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_dead <= '0;
      r_prev <= 1'b1;
      r_roll <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_prev <= event_sync;
      r_roll <= enable & (r_cnt == '1);
      if (enable) r_cnt <= r_cnt + COUNTER_WIDTH'(1);
      if (w_push)
        r_dead <= DW'(DEAD_TIME - 1);
      else if (r_state == DEAD && r_dead != '0)
        r_dead <= r_dead - DW'(1);
      if (w_drop)              r_ovf <= 1'b1;
      else if (clear_overflow) r_ovf <= 1'b0;
    end
  end

  tdc_ts_fifo #(
    .W     (COUNTER_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_input),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_data  (r_cnt),
    .i_pop   (w_pop),
    .o_data  (ts_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (ts_count)
  );

  assign ts_valid        = ~w_empty;
  assign overflow_sticky = r_ovf;
  assign rollover_pulse  = r_roll;

endmodule
